// File: rtl/mag_pkg.sv
// Shared definitions for the gradient-magnitude pipeline.
//   sq_w(in_w)    : width of gx^2+gy^2 for in_w-bit unsigned operands
//   root_w(in_w)  : width of floor(sqrt(gx^2+gy^2))
//   mag_ctl_t     : per-stage control word (valid bit)
//   MAG_LAT_EXTRA : stages beyond the square-root stages (square-sum + clamp)
package mag_pkg;

    localparam int MAG_LAT_EXTRA = 2;

    typedef struct packed {
        logic valid;
    } mag_ctl_t;

    function automatic int sq_w(input int in_w);
        return 2 * in_w + 1;
    endfunction

    function automatic int root_w(input int in_w);
        return in_w + 1;
    endfunction

endpackage

// File: rtl/sqrt_stage.sv
// Combinational slice of a restoring square root: ITERS_PS iterations, each
// consuming the top 2 bits of the radicand and producing one root bit, MSB first.
// The parent module registers the outputs and owns all flow control.
// Ports (all per lane, packed [LANES-1:0]):
//   rad_in/rad_out   : radicand bits not yet consumed, left-aligned, 2*ROOT_W bits
//   rem_in/rem_out   : partial remainder, ROOT_W+2 bits
//   root_in/root_out : partial root, ROOT_W bits
module sqrt_stage
    import mag_pkg::*;
#(
    parameter int LANES     = 5,
    parameter int SQ_W      = 17,
    parameter int ROOT_W    = 9,
    parameter int ITERS_PS  = 3,
    parameter int STAGE_IDX = 1
) (
    input  logic [LANES-1:0][2*ROOT_W-1:0] rad_in,
    input  logic [LANES-1:0][ROOT_W+1:0]   rem_in,
    input  logic [LANES-1:0][ROOT_W-1:0]   root_in,
    output logic [LANES-1:0][2*ROOT_W-1:0] rad_out,
    output logic [LANES-1:0][ROOT_W+1:0]   rem_out,
    output logic [LANES-1:0][ROOT_W-1:0]   root_out
);

    localparam int RAD_W  = 2 * ROOT_W;
    localparam int REM_W  = ROOT_W + 2;
    localparam int WORK_W = REM_W + 2;

    if (SQ_W > RAD_W || STAGE_IDX < 1) begin : g_bad_cfg
        $error("sqrt_stage: radicand wider than 2*ROOT_W or stage index below 1");
    end

    logic [RAD_W-1:0]  rad_v;
    logic [REM_W-1:0]  rem_v;
    logic [ROOT_W-1:0] root_v;
    logic [WORK_W-1:0] work_v;
    logic [WORK_W-1:0] trial_v;

    always_comb begin
        rad_out  = '0;
        rem_out  = '0;
        root_out = '0;
        rad_v    = '0;
        rem_v    = '0;
        root_v   = '0;
        work_v   = '0;
        trial_v  = '0;
        for (int l = 0; l < LANES; l++) begin
            rad_v  = rad_in[l];
            rem_v  = rem_in[l];
            root_v = root_in[l];
            for (int it = 0; it < ITERS_PS; it++) begin
                // Bring down the next radicand bit pair; trial divisor is 4*root+1.
                work_v  = {rem_v, rad_v[RAD_W-1 -: 2]};
                trial_v = {2'b00, root_v, 2'b01};
                if (work_v >= trial_v) begin
                    work_v = work_v - trial_v;
                    root_v = {root_v[ROOT_W-2:0], 1'b1};
                end else begin
                    root_v = {root_v[ROOT_W-2:0], 1'b0};
                end
                // Remainder never exceeds 2*root, so REM_W bits hold it.
                rem_v = work_v[REM_W-1:0];
                rad_v = rad_v << 2;
            end
            rad_out[l]  = rad_v;
            rem_out[l]  = rem_v;
            root_out[l] = root_v;
        end
    end

endmodule

// File: rtl/gradient_magnitude_pipe.sv
// Pipelined gradient magnitude: per lane gmag = min(floor(sqrt(gx^2+gy^2)), 2^OUT_W-1).
// Pipeline: S0 square-sum, S1..SK square-root slices (ITERS_PS root bits each),
// S(K+1) clamp register driving gmag/sat. Each stage holds its own valid bit.
// Optional feature macro: MAG_SAT_FLAG_EN adds the sat output (lane was clamped).
// Handshake: a beat moves on a port when valid && ready are both high at a rising
// clk edge; a producer holds valid and data stable until that happens. Stage i
// loads when it is empty or stage i+1 can load, so bubbles collapse and in_ready
// is combinational through the whole ready chain.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready forced low while rst_n is low)
//   gx, gy              : LANES unsigned IN_W-bit gradients, lane l at index l
//   out_valid, out_ready: output handshake
//   gmag                : LANES saturated OUT_W-bit magnitudes
//   sat                 : LANES clamp flags (MAG_SAT_FLAG_EN only)
module gradient_magnitude_pipe
    import mag_pkg::*;
#(
    parameter int LANES    = 5,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 8,
    parameter int ITERS_PS = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0][IN_W-1:0]  gx,
    input  logic [LANES-1:0][IN_W-1:0]  gy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0][OUT_W-1:0] gmag
`ifdef MAG_SAT_FLAG_EN
    ,
    output logic [LANES-1:0]            sat
`endif
);

    localparam int SQ_W   = sq_w(IN_W);
    localparam int ROOT_W = root_w(IN_W);
    localparam int K      = ROOT_W / ITERS_PS;
    localparam int N      = K + MAG_LAT_EXTRA;
    localparam int RAD_W  = 2 * ROOT_W;
    localparam int REM_W  = ROOT_W + 2;
    localparam int CW     = ((ROOT_W > OUT_W) ? ROOT_W : OUT_W) + 1;
    localparam logic [CW-1:0] OUT_MAX = CW'((64'd1 << OUT_W) - 64'd1);

    if (ROOT_W % ITERS_PS != 0) begin : g_bad_iters
        $error("gradient_magnitude_pipe: ITERS_PS must divide ROOT_W");
    end

    // ---------------- control: valid bits and ready chain ----------------
    mag_ctl_t   ctl_q [N];
    logic [N-1:0] ready;

    always_comb begin : ready_chain
        logic r;
        r     = out_ready;
        ready = '0;
        for (int i = N - 1; i >= 0; i--) begin
            r        = !ctl_q[i].valid || r;
            ready[i] = r;
        end
    end

    assign in_ready  = rst_n && ready[0];
    assign out_valid = ctl_q[N-1].valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctl_q[i] <= '0;
            end
        end else begin
            if (ready[0]) begin
                ctl_q[0].valid <= in_valid;
            end
            for (int i = 1; i < N; i++) begin
                if (ready[i]) begin
                    ctl_q[i].valid <= ctl_q[i-1].valid;
                end
            end
        end
    end

    // ---------------- datapath ----------------
    logic [LANES-1:0][SQ_W-1:0]   sum_d;
    logic [LANES-1:0][SQ_W-1:0]   sum_q;

    logic [LANES-1:0][RAD_W-1:0]  rad_src  [1:K];
    logic [LANES-1:0][REM_W-1:0]  rem_src  [1:K];
    logic [LANES-1:0][ROOT_W-1:0] root_src [1:K];
    logic [LANES-1:0][RAD_W-1:0]  rad_d    [1:K];
    logic [LANES-1:0][REM_W-1:0]  rem_d    [1:K];
    logic [LANES-1:0][ROOT_W-1:0] root_d   [1:K];
    logic [LANES-1:0][RAD_W-1:0]  rad_q    [1:K];
    logic [LANES-1:0][REM_W-1:0]  rem_q    [1:K];
    logic [LANES-1:0][ROOT_W-1:0] root_q   [1:K];

    logic [LANES-1:0][OUT_W-1:0]  gmag_d;
    logic [LANES-1:0][OUT_W-1:0]  gmag_q;
    logic [LANES-1:0]             over_d;
    logic [CW-1:0]                root_ext;

    // The final stage has consumed every radicand bit; its remainder is not needed.
    logic unused_tail;
    assign unused_tail = ^{rad_q[K], rem_q[K]};

    always_comb begin
        sum_d = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_d[l] = SQ_W'(gx[l]) * SQ_W'(gx[l]) + SQ_W'(gy[l]) * SQ_W'(gy[l]);
        end
    end

    // First root slice starts from the registered sum with empty remainder/root.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rad_src[1][l] = RAD_W'(sum_q[l]);
        end
        rem_src[1]  = '0;
        root_src[1] = '0;
        for (int k = 2; k <= K; k++) begin
            rad_src[k]  = rad_q[k-1];
            rem_src[k]  = rem_q[k-1];
            root_src[k] = root_q[k-1];
        end
    end

    for (genvar k = 1; k <= K; k++) begin : g_sqrt
        sqrt_stage #(
            .LANES    (LANES),
            .SQ_W     (SQ_W),
            .ROOT_W   (ROOT_W),
            .ITERS_PS (ITERS_PS),
            .STAGE_IDX(k)
        ) u_stage (
            .rad_in  (rad_src[k]),
            .rem_in  (rem_src[k]),
            .root_in (root_src[k]),
            .rad_out (rad_d[k]),
            .rem_out (rem_d[k]),
            .root_out(root_d[k])
        );
    end

    always_comb begin
        gmag_d   = '0;
        over_d   = '0;
        root_ext = '0;
        for (int l = 0; l < LANES; l++) begin
            root_ext  = CW'(root_q[K][l]);
            over_d[l] = root_ext > OUT_MAX;
            gmag_d[l] = over_d[l] ? {OUT_W{1'b1}} : root_ext[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            gmag_q <= '0;
            for (int k = 1; k <= K; k++) begin
                rad_q[k]  <= '0;
                rem_q[k]  <= '0;
                root_q[k] <= '0;
            end
        end else begin
            if (ready[0]) begin
                sum_q <= sum_d;
            end
            for (int k = 1; k <= K; k++) begin
                if (ready[k]) begin
                    rad_q[k]  <= rad_d[k];
                    rem_q[k]  <= rem_d[k];
                    root_q[k] <= root_d[k];
                end
            end
            if (ready[N-1]) begin
                gmag_q <= gmag_d;
            end
        end
    end

    assign gmag = gmag_q;

`ifdef MAG_SAT_FLAG_EN
    logic [LANES-1:0] sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else if (ready[N-1]) begin
            sat_q <= over_d;
        end
    end

    assign sat = sat_q;
`endif

endmodule
